// File: rtl/jal_encoder.sv
// jal_encoder: two-stage pipeline that encodes RISC-V JAL (and optionally C.J/C.JAL) instructions.
// Define JAL_ENC_COMPRESSED_EN to enable the compressed encodings; otherwise req_c=1 yields an error response.
module jal_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_rd,
    input  logic [31:0]      req_off,
    input  logic             req_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_instr,
    output logic             rsp_len,
    output logic             rsp_err,
    output logic [CNT_W-1:0] enc_cnt
);
    logic        s1_valid;
    logic [4:0]  s1_rd;
    logic [31:0] s1_off;
    logic        s1_c;
    logic        s2_adv;
    logic        j_ok;
    logic [31:0] j_instr;
    logic [31:0] enc_instr;
    logic        enc_len;
    logic        enc_err;
`ifdef JAL_ENC_COMPRESSED_EN
    logic        c_ok;
    logic [15:0] c_instr;
`endif
    assign s2_adv    = !rsp_valid || rsp_ready;
    assign req_ready = !s1_valid || s2_adv;
    // A 21-bit signed offset fits when every bit above bit 20 matches the sign.
    always_comb begin
        j_ok    = !s1_off[0] && (s1_off[31:20] == {12{s1_off[31]}});
        j_instr = {s1_off[20], s1_off[10:1], s1_off[11], s1_off[19:12], s1_rd, 7'b1101111};
    end
`ifdef JAL_ENC_COMPRESSED_EN
    always_comb begin
        c_ok    = !s1_off[0] && (s1_off[31:11] == {21{s1_off[31]}}) && (s1_rd[4:1] == 4'd0);
        c_instr = {s1_rd[0] ? 3'b001 : 3'b101, s1_off[11], s1_off[4], s1_off[9:8], s1_off[10],
                   s1_off[6], s1_off[7], s1_off[3:1], s1_off[5], 2'b01};
        enc_err   = s1_c ? !c_ok : !j_ok;
        enc_len   = s1_c && !enc_err;
        enc_instr = enc_err ? 32'd0 : (s1_c ? {16'd0, c_instr} : j_instr);
    end
`else
    always_comb begin
        enc_err   = s1_c || !j_ok;
        enc_len   = 1'b0;
        enc_instr = enc_err ? 32'd0 : j_instr;
    end
`endif
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            s1_rd  <= req_rd;
            s1_off <= req_off;
            s1_c   <= req_c;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_instr <= 32'd0;
            rsp_len   <= 1'b0;
            rsp_err   <= 1'b0;
            enc_cnt   <= '0;
        end else begin
            if (req_valid && req_ready)
                s1_valid <= 1'b1;
            else if (s2_adv)
                s1_valid <= 1'b0;
            if (s2_adv) begin
                rsp_valid <= s1_valid;
                if (s1_valid) begin
                    rsp_instr <= enc_instr;
                    rsp_len   <= enc_len;
                    rsp_err   <= enc_err;
                end
            end
            if (rsp_valid && rsp_ready && !rsp_err)
                enc_cnt <= enc_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_jal_encoder.sv
// tb_jal_encoder: randomized and directed checks of jal_encoder against an arithmetic reference model.
// Expectations follow JAL_ENC_COMPRESSED_EN the same way the design does.
module tb_jal_encoder;
    localparam int CW = 3;
    localparam logic [33:0] ERR = {2'b10, 32'h0};
`ifdef JAL_ENC_COMPRESSED_EN
    localparam logic [33:0] EXP_CJ   = {2'b01, 32'h0000BFFD};
    localparam logic [33:0] EXP_CJAL = {2'b01, 32'h00002FFD};
`else
    localparam logic [33:0] EXP_CJ   = ERR;
    localparam logic [33:0] EXP_CJAL = ERR;
`endif
    logic          clk = 1'b0;
    logic          rst, req_valid, req_ready, req_c, rsp_valid, rsp_ready, rsp_len, rsp_err;
    logic [4:0]    req_rd;
    logic [31:0]   req_off, rsp_instr;
    logic [CW-1:0] enc_cnt;
    int            vectors = 0;
    int            fails = 0;
    logic [33:0]   exp_q[$];
    logic [33:0]   obs_q[$];

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] off;
        logic        c;
        logic [33:0] exp;
    } dcase_t;

    jal_encoder #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_off(req_off), .req_c(req_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_len(rsp_len), .rsp_err(rsp_err), .enc_cnt(enc_cnt)
    );

    always #5 clk = ~clk;

    // Reference: {err, len, instr} from the offset value and the field layout of each format.
    function automatic logic [33:0] model(input logic [4:0] rd, input logic [31:0] off, input logic c);
        int          so;
        logic [31:0] ins;
        so = off;
        if (c) begin
`ifdef JAL_ENC_COMPRESSED_EN
            if (off[0] || so < -2048 || so > 2046 || rd > 5'd1) return ERR;
            ins = ((rd == 5'd0 ? 32'h5 : 32'h1) << 13) | (((off >> 11) & 32'h1) << 12)
                | (((off >> 4) & 32'h1) << 11) | (((off >> 8) & 32'h3) << 9)
                | (((off >> 10) & 32'h1) << 8) | (((off >> 6) & 32'h1) << 7)
                | (((off >> 7) & 32'h1) << 6) | (((off >> 1) & 32'h7) << 3)
                | (((off >> 5) & 32'h1) << 2) | 32'h1;
            return {2'b01, ins};
`else
            return ERR;
`endif
        end
        if (off[0] || so < -1048576 || so > 1048574) return ERR;
        ins = (((off >> 20) & 32'h1) << 31) | (((off >> 1) & 32'h3FF) << 21)
            | (((off >> 11) & 32'h1) << 20) | (((off >> 12) & 32'hFF) << 12)
            | (32'(rd) << 7) | 32'h6F;
        return {2'b00, ins};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            obs_q.delete();
        end else begin
            if (req_valid && req_ready) exp_q.push_back(model(req_rd, req_off, req_c));
            if (rsp_valid && rsp_ready) obs_q.push_back({rsp_err, rsp_len, rsp_instr});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_rd = 5'd0;
        req_off = 32'd0;
        req_c = 1'b0;
        do_reset();
        tick();
        do_reset();
        vectors++;
        if ({rsp_valid, req_ready, enc_cnt, rsp_instr, rsp_len, rsp_err} !== {1'b0, 1'b1, {CW{1'b0}}, 32'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state got v=%b rdy=%b cnt=%0d instr=%h len=%b err=%b want v=0 rdy=1 cnt=0 instr=0 len=0 err=0",
                     rsp_valid, req_ready, enc_cnt, rsp_instr, rsp_len, rsp_err);
        end
    endtask

    task automatic test_directed();
        dcase_t        t[10];
        logic [CW-1:0] cnt_exp;
        t[0] = '{5'd1, 32'h00000800, 1'b0, {2'b00, 32'h001000EF}};
        t[1] = '{5'd3, 32'h00000003, 1'b0, ERR};
        t[2] = '{5'd3, 32'h00100000, 1'b0, ERR};
        t[3] = '{5'd0, 32'd2048, 1'b1, ERR};
        t[4] = '{5'd5, 32'd4, 1'b1, ERR};
        t[5] = '{5'd0, 32'hFFFFFFFE, 1'b1, EXP_CJ};
        t[6] = '{5'd1, 32'd2046, 1'b1, EXP_CJAL};
        t[7] = '{5'd2, 32'h000FFFFE, 1'b0, {2'b00, 32'h7FFFF16F}};
        t[8] = '{5'd0, 32'hFFF00000, 1'b0, {2'b00, 32'h8000006F}};
        t[9] = '{5'd0, 32'hFFEFFFFE, 1'b0, ERR};
        do_reset();
        rsp_ready = 1'b1;
        cnt_exp = '0;
        foreach (t[i]) begin
            req_valid = 1'b1;
            req_rd = t[i].rd;
            req_off = t[i].off;
            req_c = t[i].c;
            tick();
            req_valid = 1'b0;
            vectors++;
            if (rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL latency_early case %0d got rsp_valid=%b want 0", i, rsp_valid);
            end
            tick();
            vectors++;
            if ({rsp_valid, rsp_err, rsp_len, rsp_instr} !== {1'b1, t[i].exp}) begin
                fails++;
                $display("FAIL directed case %0d got v=%b err=%b len=%b instr=%h want v=1 err=%b len=%b instr=%h",
                         i, rsp_valid, rsp_err, rsp_len, rsp_instr, t[i].exp[33], t[i].exp[32], t[i].exp[31:0]);
            end
            tick();
            if (!t[i].exp[33]) cnt_exp = cnt_exp + 1'b1;
            vectors++;
            if (enc_cnt !== cnt_exp) begin
                fails++;
                $display("FAIL directed_cnt case %0d got enc_cnt=%0d want %0d", i, enc_cnt, cnt_exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rd[3];
        logic [31:0] off[3];
        logic [33:0] held;
        int          idx;
        int          budget;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rd[i] = 5'($urandom_range(0, 31));
            off[i] = 32'(int'($urandom_range(0, 4095)) * 2 - 4096);
        end
        idx = 0;
        held = '0;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1;
            req_rd = rd[idx];
            req_off = off[idx];
            req_c = 1'b0;
            if (req_ready) idx++;
            tick();
            if (k == 1) held = {rsp_err, rsp_len, rsp_instr};
            if (k >= 2) begin
                vectors++;
                if ({rsp_valid, rsp_err, rsp_len, rsp_instr} !== {1'b1, held}) begin
                    fails++;
                    $display("FAIL stall_hold cycle %0d got v=%b out=%h want v=1 out=%h", k, rsp_valid, {rsp_err, rsp_len, rsp_instr}, held);
                end
            end
        end
        vectors++;
        if ({idx, req_ready} !== {32'd2, 1'b0}) begin
            fails++;
            $display("FAIL stall_accepts got accepted=%0d req_ready=%b want accepted=2 req_ready=0", idx, req_ready);
        end
        vectors++;
        if (held !== model(rd[0], off[0], 1'b0)) begin
            fails++;
            $display("FAIL stall_head got %h want %h", held, model(rd[0], off[0], 1'b0));
        end
        rsp_ready = 1'b1;
        budget = 0;
        while (idx < 3 && budget < 10) begin
            req_rd = rd[idx];
            req_off = off[idx];
            if (req_ready) idx++;
            tick();
            budget++;
        end
        req_valid = 1'b0;
        budget = 0;
        while (obs_q.size() < 3 && budget < 20) begin
            tick();
            budget++;
        end
        vectors++;
        if (obs_q.size() != 3) begin
            fails++;
            $display("FAIL release_count got %0d responses want 3", obs_q.size());
        end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== model(rd[i], off[i], 1'b0)) begin
                fails++;
                $display("FAIL release_order item %0d got %h want %h", i, obs_q[i], model(rd[i], off[i], 1'b0));
            end
        end
        vectors++;
        if (enc_cnt !== CW'(3)) begin
            fails++;
            $display("FAIL release_cnt got enc_cnt=%0d want 3", enc_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_rd = 5'd7;
        req_off = 32'h00000100;
        req_c = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        req_valid = 1'b0;
        vectors++;
        if ({rsp_valid, req_ready} !== 2'b10) begin
            fails++;
            $display("FAIL midflight_full got v=%b rdy=%b want v=1 rdy=0", rsp_valid, req_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({rsp_valid, enc_cnt, req_ready} !== {1'b0, {CW{1'b0}}, 1'b1}) begin
            fails++;
            $display("FAIL midflight_reset got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", rsp_valid, enc_cnt, req_ready);
        end
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen = seen | rsp_valid;
        end
        vectors++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL midflight_stale got rsp_valid=1 after reset want 0");
        end
    endtask

    task automatic test_random();
        int            b[8];
        logic [33:0]   prev;
        logic          prev_stall;
        int            v;
        int            budget;
        logic [CW-1:0] cnt_exp;
        b = '{2046, 2048, -2048, -2050, 1048574, 1048576, -1048576, -1048578};
        do_reset();
        prev = '0;
        prev_stall = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (prev_stall) begin
                vectors++;
                if ({rsp_valid, rsp_err, rsp_len, rsp_instr} !== {1'b1, prev}) begin
                    fails++;
                    $display("FAIL random_hold cycle %0d got v=%b out=%h want v=1 out=%h", n, rsp_valid, {rsp_err, rsp_len, rsp_instr}, prev);
                end
            end
            req_valid = $urandom_range(0, 3) != 0;
            rsp_ready = $urandom_range(0, 2) != 0;
            case ($urandom_range(0, 3))
                0:       req_rd = 5'd0;
                1:       req_rd = 5'd1;
                default: req_rd = 5'($urandom_range(0, 31));
            endcase
            req_c = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       v = int'($urandom_range(0, 2047)) * 2 - 2048;
                1:       v = int'($urandom());
                2:       v = int'($urandom_range(0, 1048575)) * 2 - 1048576;
                3:       v = b[$urandom_range(0, 7)];
                4:       v = int'($urandom_range(0, 2047)) * 2 - 2047;
                default: v = 0;
            endcase
            req_off = 32'(v);
            prev = {rsp_err, rsp_len, rsp_instr};
            prev_stall = rsp_valid && !rsp_ready;
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        budget = 0;
        while (rsp_valid && budget < 10) begin
            tick();
            budget++;
        end
        tick();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL random_count got %0d responses want %0d", obs_q.size(), exp_q.size());
        end
        cnt_exp = '0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL random_resp item %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        foreach (exp_q[i]) if (!exp_q[i][33]) cnt_exp = cnt_exp + 1'b1;
        vectors++;
        if (enc_cnt !== cnt_exp) begin
            fails++;
            $display("FAIL random_cnt got enc_cnt=%0d want %0d", enc_cnt, cnt_exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
